// File: rtl/dbg_snapshot_server.sv
// dbg_snapshot_server: halts the core, snapshots registers and probes into
// shadow storage and serves them to the VGA debug display with 1-cycle latency.
// Optional live-read path enabled by defining DBG_LIVE_EN (adds live_sel).
module dbg_snapshot_server #(
    parameter int NPROBE       = 24,
    parameter int HALT_TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            debug_addr,
    output logic [31:0]           debug_data,
    input  logic                  snap_req,
    output logic                  cpu_hold,
    input  logic                  cpu_halted,
    output logic [4:0]            rf_raddr,
    input  logic [31:0]           rf_rdata,
    input  logic [NPROBE*32-1:0]  probe_bus,
`ifdef DBG_LIVE_EN
    input  logic                  live_sel,
`endif
    output logic                  snap_valid,
    output logic                  snap_busy,
    output logic                  snap_err
);

    localparam int TW = $clog2(HALT_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(HALT_TIMEOUT - 1);
    localparam logic [5:0] NP6 = 6'(NPROBE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_PROBE,
        S_COPY,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_hold;
    logic            r_valid;
    logic            r_err;
    logic            r_pend;
    logic [4:0]      r_raddr;
    logic [TW-1:0]   r_tmo;
    logic [31:0]     r_data;
    logic [31:0]     r_reg_sh [32];
    logic [31:0]     r_prb_sh [32];

    logic [1023:0]   w_probe_pad;
    logic [4:0]      w_idx;
    logic [31:0]     w_rd;
    logic            w_live_reg;
    logic            w_live_prb;

    // Probe words beyond NPROBE read as zero through the padded bus.
    assign w_probe_pad = 1024'(probe_bus);
    assign w_idx       = debug_addr[4:0];

`ifdef DBG_LIVE_EN
    assign w_live_reg = live_sel && (r_state == S_IDLE);
    assign w_live_prb = live_sel;
`else
    assign w_live_reg = 1'b0;
    assign w_live_prb = 1'b0;
`endif

    assign rf_raddr   = w_live_reg ? w_idx : r_raddr;
    assign cpu_hold   = r_hold;
    assign snap_valid = r_valid;
    assign snap_err   = r_err;
    assign snap_busy  = (r_state != S_IDLE);
    assign debug_data = r_data;

    // Sequencer: halt, wait for ack (with timeout), copy probes, copy regs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hold  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_pend  <= 1'b0;
            r_raddr <= 5'd0;
            r_tmo   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (snap_req) begin
                        r_state <= S_HALT;
                        r_hold  <= 1'b1;
                        r_err   <= 1'b0;
                        r_tmo   <= '0;
                    end
                end
                S_HALT: begin
                    if (snap_req) r_pend <= 1'b1;
                    if (cpu_halted) begin
                        r_state <= S_PROBE;
                    end else if (r_tmo == TMO_LAST) begin
                        // Abort; a merged request fails along with it.
                        r_state <= S_IDLE;
                        r_hold  <= 1'b0;
                        r_err   <= 1'b1;
                        r_pend  <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_PROBE: begin
                    if (snap_req) r_pend <= 1'b1;
                    r_raddr <= 5'd1;
                    r_state <= S_COPY;
                end
                S_COPY: begin
                    if (snap_req) r_pend <= 1'b1;
                    r_raddr <= r_raddr + 5'd1;
                    if (r_raddr == 5'd31) begin
                        // Release the core for the single DONE cycle.
                        r_state <= S_DONE;
                        r_hold  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b1;
                    r_raddr <= 5'd0;
                    if (r_pend || snap_req) begin
                        r_state <= S_HALT;
                        r_hold  <= 1'b1;
                        r_pend  <= 1'b0;
                        r_err   <= 1'b0;
                        r_tmo   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_hold  <= 1'b0;
                end
            endcase
        end
    end

    // Shadow storage: probes captured in one cycle, registers one per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) begin
                r_reg_sh[k] <= 32'h0;
                r_prb_sh[k] <= 32'h0;
            end
        end else begin
            if (r_state == S_PROBE) begin
                for (int k = 0; k < 32; k++) begin
                    r_prb_sh[k] <= w_probe_pad[k*32 +: 32];
                end
            end
            if (r_state == S_COPY && r_raddr != 5'd0) begin
                r_reg_sh[r_raddr] <= rf_rdata;
            end
        end
    end

    // Read mux: register page, probe page, everything else zero.
    always_comb begin
        w_rd = 32'h0;
        if (!debug_addr[6]) begin
            if (!debug_addr[5]) begin
                if (w_idx != 5'd0) begin
                    w_rd = w_live_reg ? rf_rdata : r_reg_sh[w_idx];
                end
            end else if ({1'b0, w_idx} < NP6) begin
                w_rd = w_live_prb ? w_probe_pad[{w_idx, 5'b0} +: 32]
                                  : r_prb_sh[w_idx];
            end
        end
    end

    // Registered read data gives the fixed 1-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= 32'h0;
        end else begin
            r_data <= w_rd;
        end
    end

endmodule
